ifu_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the combinational instruction ROM.
- Owns the architectural PC and drives the ROM address. Captures the returned instruction together with its PC into a small FIFO.
- Presents {pc, inst} to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from downstream and flushes all queued, wrong-path instructions.

---
 rtl/ifu_fetch.sv | 108 ++++++++++
 tb/tb_ifu_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, reads the combinational ROM and queues {pc, inst} for decode; redirects flush the queue.
// Define IFU_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
module ifu_fetch #(
  parameter int unsigned     XLEN   = 64,
  parameter int unsigned     INST_W = 32,
  parameter logic [XLEN-1:0] PC_RST = 64'h0000_0000_8000_0000,
  parameter int unsigned     DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [XLEN-1:0]   rom_pc,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [XLEN-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst
`ifdef IFU_PERF_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_stall_cnt
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW = XLEN + INST_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            enq, deq;

  // The full test uses the pre-dequeue count, so a full FIFO never refills in the cycle it drains.
  assign enq = (cnt_q < DEPTH_C) & ~redirect_valid;
  assign deq = id_valid & id_ready;

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & ~XLEN'(3);
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (enq) begin
        pc_d     = pc_q + XLEN'(4);
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      cnt_d = cnt_q + (AW+1)'(enq) - (AW+1)'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= PC_RST;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (enq) begin
        mem_q[wr_ptr_q] <= {pc_q, rom_inst};
      end
    end
  end

  assign rom_pc           = pc_q;
  assign id_valid         = (cnt_q != '0);
  assign {id_pc, id_inst} = mem_q[rd_ptr_q];

`ifdef IFU_PERF_EN
  logic [63:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (enq) begin
        fetch_cnt_q <= fetch_cnt_q + 64'd1;
      end
      if ((cnt_q == DEPTH_C) && !redirect_valid) begin
        stall_cnt_q <= stall_cnt_q + 64'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: expected pc stream is queued when reset/redirect is driven and checked on each decode handshake.
module tb_ifu_fetch;

  localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] rom_pc;
  logic [31:0] rom_inst;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
`ifdef IFU_PERF_EN
  logic [63:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_hs     = 0;
  logic [63:0] exp_q[$];
  logic [63:0] m_pc;

  ifu_fetch #(.XLEN(64), .INST_W(32), .PC_RST(PC_RST), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rom_pc(rom_pc), .rom_inst(rom_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
`ifdef IFU_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [63:0] pc);
    return 32'hC0DE_0000 ^ pc[33:2];
  endfunction

  assign rom_inst = rom_word(rom_pc);

  task automatic load_stream(input logic [63:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(base + 64'(4 * i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake must deliver the next expected pc; reset/redirect restart the stream.
  always @(negedge clk) begin
    if (!rst_n) begin
      load_stream(PC_RST);
    end else begin
      if (id_valid && id_ready) begin
        n_hs++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL handshake: got pc=%h, no entry expected", id_pc);
        end else begin
          m_pc = exp_q.pop_front();
          if (id_pc !== m_pc || id_inst !== rom_word(m_pc)) begin
            n_fail++;
            $display("FAIL handshake: got pc=%h inst=%h, want pc=%h inst=%h",
                     id_pc, id_inst, m_pc, rom_word(m_pc));
          end
        end
      end
      if (redirect_valid) load_stream(redirect_pc & ~64'h3);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
    n_checks++; if (id_pc !== 64'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
    n_checks++; if (id_inst !== 32'h0) begin n_fail++; $display("FAIL reset_id_inst: got %h want 0", id_inst); end
    n_checks++; if (rom_pc !== PC_RST) begin n_fail++; $display("FAIL reset_rom_pc: got %h want %h", rom_pc, PC_RST); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL release_id_valid: got %b want 0", id_valid); end
    n_checks++; if (rom_pc !== PC_RST) begin n_fail++; $display("FAIL release_rom_pc: got %h want %h", rom_pc, PC_RST); end
    tick();
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL first_id_valid: got %b want 1", id_valid); end
    n_checks++; if (id_pc !== PC_RST || id_inst !== rom_word(PC_RST)) begin n_fail++; $display("FAIL first_entry: got %h/%h want %h/%h", id_pc, id_inst, PC_RST, rom_word(PC_RST)); end
    n_checks++; if (rom_pc !== PC_RST + 64'd4) begin n_fail++; $display("FAIL first_rom_pc: got %h want %h", rom_pc, PC_RST + 64'd4); end
`ifdef IFU_PERF_EN
    n_checks++; if (perf_fetch_cnt !== 64'd1 || perf_stall_cnt !== 64'd0) begin n_fail++; $display("FAIL perf_early: got %0d/%0d want 1/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
    repeat (3) tick();
`ifdef IFU_PERF_EN
    @(negedge clk);
    n_checks++; if (perf_fetch_cnt !== 64'd2 || perf_stall_cnt !== 64'd2) begin n_fail++; $display("FAIL perf_stall: got %0d/%0d want 2/2", perf_fetch_cnt, perf_stall_cnt); end
    tick();
`endif
  endtask

  task automatic test_stream();
    int hs0;
    hs0 = n_hs;
    id_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    n_checks++; if (n_hs - hs0 !== 10) begin n_fail++; $display("FAIL stream_rate: got %0d handshakes want 10", n_hs - hs0); end
    tick();
  endtask

  task automatic test_stall();
    logic [63:0] h;
    id_ready = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    h = exp_q[0];
    n_checks++; if (id_valid !== 1'b1 || id_pc !== h) begin n_fail++; $display("FAIL stall_head: got %b/%h want 1/%h", id_valid, id_pc, h); end
    n_checks++; if (rom_pc !== h + 64'd8) begin n_fail++; $display("FAIL stall_rom_pc: got %h want %h", rom_pc, h + 64'd8); end
    tick();
    id_ready = 1'b1;
    tick();
    @(negedge clk);
    n_checks++; if (rom_pc !== h + 64'd8) begin n_fail++; $display("FAIL resume_no_enq_full: got %h want %h", rom_pc, h + 64'd8); end
    repeat (6) tick();
  endtask

  task automatic test_redirect();
    id_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got id_valid %b want 0", id_valid); end
    n_checks++; if (rom_pc !== 64'h8000_0100) begin n_fail++; $display("FAIL redir_rom_pc: got %h want 80000100", rom_pc); end
    tick();
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8000_0100) begin n_fail++; $display("FAIL redir_target: got %b/%h want 1/80000100", id_valid, id_pc); end
    tick();
    id_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (rom_pc !== 64'h8000_0100) begin n_fail++; $display("FAIL misaligned_rom_pc: got %h want 80000100", rom_pc); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL misaligned_flush: got %b want 0", id_valid); end
    repeat (5) tick();
  endtask

  task automatic test_redirect_deq();
    int hs0;
    id_ready = 1'b0;
    repeat (3) tick();
    hs0 = n_hs;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; id_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_deq_flush: got %b want 0", id_valid); end
    n_checks++; if (n_hs - hs0 !== 1) begin n_fail++; $display("FAIL redir_deq_count: got %0d handshakes want 1", n_hs - hs0); end
    repeat (5) tick();
  endtask

  task automatic test_held_redirect();
    logic [63:0] t;
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      redirect_valid = 1'b1;
      redirect_pc = 64'h8000_0300 + 64'(k * 'h40);
      @(negedge clk);
      if (k > 0) begin
        n_checks++; if (rom_pc !== t || id_valid !== 1'b0) begin n_fail++; $display("FAIL held_redirect: got %h/%b want %h/0", rom_pc, id_valid, t); end
      end
      t = redirect_pc;
      tick();
    end
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (rom_pc !== t || id_valid !== 1'b0) begin n_fail++; $display("FAIL held_redirect_last: got %h/%b want %h/0", rom_pc, id_valid, t); end
    repeat (5) tick();
  endtask

  task automatic test_async_reset();
    id_ready = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL async_id_valid: got %b want 0", id_valid); end
    n_checks++; if (rom_pc !== PC_RST) begin n_fail++; $display("FAIL async_rom_pc: got %h want %h", rom_pc, PC_RST); end
    n_checks++; if (id_pc !== 64'h0) begin n_fail++; $display("FAIL async_id_pc: got %h want 0", id_pc); end
`ifdef IFU_PERF_EN
    n_checks++; if (perf_fetch_cnt !== 64'd0 || perf_stall_cnt !== 64'd0) begin n_fail++; $display("FAIL async_perf: got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0 || rom_pc !== PC_RST) begin n_fail++; $display("FAIL async_release: got %b/%h want 0/%h", id_valid, rom_pc, PC_RST); end
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_redirect_deq();
    test_held_redirect();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
